acq_sequencer: RTL

Parametrised acquisition sequencer for the Raman accumulation path. Per armed run it waits for an external laser/ADC sync pulse, then drives a write-request window for one shot of `points` samples into the accumulation FIFO. It drives a read-request window, delayed by a fixed pipeline latency, to fetch the running sum. It repeats for `measures` shots, flags first/last shot to the adder, reports trigger overruns, and signals completion.

---
 rtl/acq_pkg.sv | 16 +
 rtl/sync_edge_det.sv | 35 +++
 rtl/acq_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/acq_pkg.sv
// Shared types and default widths for the Raman acquisition sequencer.
package acq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_SHOT  = 2'd2,
        S_DONE  = 2'd3
    } acq_state_t;

    localparam int PW_DEF          = 11;
    localparam int MW_DEF          = 17;
    localparam int RD_LAT_DEF      = 3;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous trigger plus a registered
// rising-edge detector producing a one-cycle trig pulse.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic trig
);

    logic [STAGES-1:0] r_sync;
    logic [STAGES:0]   r_vld;
    logic              r_prev;
    logic              r_trig;

    // r_vld marks when r_sync/r_prev hold real samples rather than reset
    // zeros, so a line already high at reset release never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_vld  <= '0;
            r_prev <= 1'b0;
            r_trig <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], async_in};
            r_vld  <= {r_vld[STAGES-1:0], 1'b1};
            r_prev <= r_sync[STAGES-1];
            r_trig <= r_vld[STAGES] & r_sync[STAGES-1] & ~r_prev;
        end
    end

    assign trig = r_trig;

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: per sync trigger drives a write window of `points`
// samples and a read window lagging by RD_LAT, for `measures` shots per run.
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int PW          = PW_DEF,
    parameter int MW          = MW_DEF,
    parameter int RD_LAT      = RD_LAT_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          sync,
    input  logic [PW-1:0] points,
    input  logic [MW-1:0] measures,
    output logic          wrreq,
    output logic          rdreq,
    output logic [PW-1:0] sample_idx,
    output logic [MW-1:0] shot_idx,
    output logic          first_shot,
    output logic          last_shot,
    output logic          busy,
    output logic          done,
    output logic          overrun
);

    localparam int CW = PW + 4;

    acq_state_t    r_state;
    logic [PW-1:0] r_points_l;
    logic [MW-1:0] r_measures_l;
    logic [CW-1:0] r_cyc;
    logic [MW-1:0] r_shot_idx;
    logic [PW-1:0] r_sample_idx;
    logic          r_wrreq;
    logic          r_rdreq;
    logic          r_first;
    logic          r_last;
    logic          r_busy;
    logic          r_done;
    logic          r_overrun;

    logic          w_trig;
    logic [CW-1:0] w_cyc_nxt;
    logic [CW-1:0] w_shot_len;
    logic          w_last_cyc;
    logic          w_last_shot;
    logic [MW-1:0] w_shot_nxt;
    logic          w_wr_nxt;
    logic          w_rd_nxt;

    sync_edge_det #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_in(sync),
        .trig    (w_trig)
    );

    // Outputs are decoded from the cycle count about to be loaded so that
    // they line up with r_cyc once registered.
    assign w_shot_len  = {4'b0, r_points_l} + CW'(RD_LAT);
    assign w_cyc_nxt   = r_cyc + CW'(1);
    assign w_last_cyc  = (r_cyc == w_shot_len - CW'(1));
    assign w_last_shot = (r_shot_idx == r_measures_l - MW'(1));
    assign w_shot_nxt  = r_shot_idx + MW'(1);
    assign w_wr_nxt    = (w_cyc_nxt < {4'b0, r_points_l});
    assign w_rd_nxt    = (r_shot_idx != '0) && (w_cyc_nxt >= CW'(RD_LAT))
                         && (w_cyc_nxt < w_shot_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_points_l   <= '0;
            r_measures_l <= '0;
            r_cyc        <= '0;
            r_shot_idx   <= '0;
            r_sample_idx <= '0;
            r_wrreq      <= 1'b0;
            r_rdreq      <= 1'b0;
            r_first      <= 1'b0;
            r_last       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            if (abort) begin
                r_state      <= S_IDLE;
                r_cyc        <= '0;
                r_shot_idx   <= '0;
                r_sample_idx <= '0;
                r_wrreq      <= 1'b0;
                r_rdreq      <= 1'b0;
                r_first      <= 1'b0;
                r_last       <= 1'b0;
                r_busy       <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && (points != '0) && (measures != '0)) begin
                            r_points_l   <= points;
                            r_measures_l <= measures;
                            r_shot_idx   <= '0;
                            r_first      <= 1'b1;
                            r_last       <= (measures == MW'(1));
                            r_busy       <= 1'b1;
                            r_state      <= S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        if (w_trig) begin
                            r_cyc        <= '0;
                            r_sample_idx <= '0;
                            r_wrreq      <= 1'b1;
                            r_rdreq      <= 1'b0;
                            r_state      <= S_SHOT;
                        end
                    end
                    S_SHOT: begin
                        r_overrun <= w_trig;
                        if (w_last_cyc) begin
                            r_wrreq <= 1'b0;
                            r_rdreq <= 1'b0;
                            if (w_last_shot) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_shot_idx <= w_shot_nxt;
                                r_first    <= 1'b0;
                                r_last     <= (w_shot_nxt == r_measures_l - MW'(1));
                                r_state    <= S_ARMED;
                            end
                        end else begin
                            r_cyc        <= w_cyc_nxt;
                            r_sample_idx <= w_cyc_nxt[PW-1:0];
                            r_wrreq      <= w_wr_nxt;
                            r_rdreq      <= w_rd_nxt;
                        end
                    end
                    S_DONE: begin
                        r_overrun  <= w_trig;
                        r_shot_idx <= '0;
                        r_first    <= 1'b0;
                        r_last     <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign wrreq      = r_wrreq;
    assign rdreq      = r_rdreq;
    assign sample_idx = r_sample_idx;
    assign shot_idx   = r_shot_idx;
    assign first_shot = r_first;
    assign last_shot  = r_last;
    assign busy       = r_busy;
    assign done       = r_done;
    assign overrun    = r_overrun;

endmodule
